// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared state encoding and sizing helper for the iterative divider
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH_DEF = 32;

    // Counter must be able to hold the value N_WIDTH itself.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_abs.sv
// ============================================================================
// div_abs : conditional two's-complement negate (operand abs / result sign fix)
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_abs #(
    parameter int N_WIDTH = 32
) (
    input  logic               i_neg,
    input  logic [N_WIDTH-1:0] i_val,
    output logic [N_WIDTH-1:0] o_val
);

    assign o_val = i_neg ? -i_val : i_val;

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit : radix-2 restoring divider, signed/unsigned, fixed latency
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_unit
    import div_pkg::*;
#(
    parameter int N_WIDTH = DIV_WIDTH_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_divsigned,
    input  logic               i_divstart,
    input  logic [N_WIDTH-1:0] i_dividend,
    input  logic [N_WIDTH-1:0] i_divisor,
    output logic [N_WIDTH-1:0] o_quotient,
    output logic [N_WIDTH-1:0] o_remainder,
    output logic               o_done_vld,
    output logic               o_ready
);

    localparam int                c_cnt_w     = cnt_width(N_WIDTH);
    localparam logic [c_cnt_w-1:0] c_iter_last = c_cnt_w'(N_WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    div_state_e          r_state;
    div_state_e          w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [N_WIDTH-1:0]  r_dvd;
    logic [N_WIDTH-1:0]  r_dvs;
    logic [N_WIDTH-1:0]  r_rem;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [N_WIDTH-1:0]  r_quo_out;
    logic [N_WIDTH-1:0]  r_rem_out;

    logic                w_dvd_neg;
    logic                w_dvs_neg;
    logic                w_dvs_zero;
    logic [N_WIDTH-1:0]  w_dvd_abs;
    logic [N_WIDTH-1:0]  w_dvs_abs;
    logic [N_WIDTH-1:0]  w_quo_fix;
    logic [N_WIDTH-1:0]  w_rem_fix;
    logic [N_WIDTH:0]    w_shift;
    logic                w_ge;
    logic [N_WIDTH-1:0]  w_sub;

    assign w_dvd_neg  = i_divsigned & i_dividend[N_WIDTH-1];
    assign w_dvs_neg  = i_divsigned & i_divisor[N_WIDTH-1];
    assign w_dvs_zero = (i_divisor == '0);

    div_abs #(.N_WIDTH(N_WIDTH)) u_abs_dvd (.i_neg(w_dvd_neg), .i_val(i_dividend), .o_val(w_dvd_abs));
    div_abs #(.N_WIDTH(N_WIDTH)) u_abs_dvs (.i_neg(w_dvs_neg), .i_val(i_divisor),  .o_val(w_dvs_abs));
    div_abs #(.N_WIDTH(N_WIDTH)) u_fix_quo (.i_neg(r_neg_q),   .i_val(r_dvd),      .o_val(w_quo_fix));
    div_abs #(.N_WIDTH(N_WIDTH)) u_fix_rem (.i_neg(r_neg_r),   .i_val(r_rem),      .o_val(w_rem_fix));

    // Compare on N+1 bits; when it succeeds the true difference is below the
    // divisor, so the low N bits of the subtraction are exact.
    assign w_shift = {r_rem, r_dvd[N_WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[N_WIDTH-1:0] - r_dvs;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_divstart) w_state_nxt = w_dvs_zero ? ZERO : BUSY;
            BUSY:    if (r_cnt == c_iter_last) w_state_nxt = DONE;
            ZERO:    if (r_cnt != '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_dvd holds the shifting dividend and collects quotient bits from the LSB.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_quo_out <= '0;
            r_rem_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_divstart) begin
                        r_dvd   <= w_dvs_zero ? i_dividend : w_dvd_abs;
                        r_dvs   <= w_dvs_abs;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                    end
                end
                BUSY: begin
                    if (r_cnt != c_iter_last) begin
                        r_rem <= w_ge ? w_sub : w_shift[N_WIDTH-1:0];
                        r_dvd <= {r_dvd[N_WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + c_cnt_one;
                    end else begin
                        r_quo_out <= w_quo_fix;
                        r_rem_out <= w_rem_fix;
                    end
                end
                ZERO: begin
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt != '0) begin
                        r_quo_out <= '1;
                        r_rem_out <= r_dvd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_quotient  = r_quo_out;
    assign o_remainder = r_rem_out;
    assign o_done_vld  = (r_state == DONE);
    assign o_ready     = (r_state == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit : directed vectors, corner sequences and random ops vs. model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_divsigned;
    logic        i_divstart;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_done_vld;
    logic        o_ready;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[12];

    div_unit #(.N_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_divsigned (i_divsigned),
        .i_divstart  (i_divstart),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_done_vld  (o_done_vld),
        .o_ready     (o_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Truncating division computed on 64-bit integers.
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            q  = 32'(ua / ub);
            r  = 32'(ua % ub);
        end
    endfunction

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int          lat;
        int          exp_lat;
        logic [31:0] q0, r0;
        logic        stable;
        exp_lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        check({tag, " ready_before"}, 32'(o_ready), 32'd1);
        q0 = o_quotient;
        r0 = o_remainder;
        stable = 1'b1;
        i_divsigned = sgn;
        i_dividend  = a;
        i_divisor   = b;
        i_divstart  = 1'b1;
        @(posedge clk); #1;
        i_divstart  = 1'b0;
        i_dividend  = $urandom;
        i_divisor   = $urandom;
        i_divsigned = 1'($urandom_range(0, 1));
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (o_done_vld) lat = k;
            else if (o_quotient !== q0 || o_remainder !== r0 || o_ready) stable = 1'b0;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " hold_busy"}, 32'(stable), 32'd1);
        check({tag, " quotient"}, o_quotient, eq);
        check({tag, " remainder"}, o_remainder, er);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'd0, o_done_vld, o_ready}, 32'd1);
        check({tag, " quot_held"}, o_quotient, eq);
    endtask

    initial begin
        logic [31:0] mq, mr, a, b;
        logic        s;
        int          e, lat, spurious;

        vecs[0]  = '{1'b1, 32'hFFFFFFFA, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[1]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2};
        vecs[2]  = '{1'b0, 32'hFFFFFFFA, 32'd5,        32'h33333332, 32'd0};
        vecs[3]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        vecs[5]  = '{1'b0, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678};
        vecs[6]  = '{1'b1, 32'h87654321, 32'd0,        32'hFFFFFFFF, 32'h87654321};
        vecs[7]  = '{1'b0, 32'h80000000, 32'h80000000, 32'd1,        32'd0};
        vecs[8]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[9]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
        vecs[10] = '{1'b0, 32'd5,        32'hFFFFFFFF, 32'd0,        32'd5};
        vecs[11] = '{1'b1, 32'h80000000, 32'd1,        32'h80000000, 32'd0};

        rst = 1'b1;
        i_divsigned = 1'b0;
        i_divstart  = 1'b0;
        i_dividend  = '0;
        i_divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset quotient", o_quotient, 32'd0);
        check("reset remainder", o_remainder, 32'd0);
        check("reset flags", {30'd0, o_done_vld, o_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r);

        // Start pulse while busy must be ignored.
        @(negedge clk);
        i_divsigned = 1'b0; i_dividend = 32'd1000; i_divisor = 32'd3; i_divstart = 1'b1;
        @(posedge clk); #1;
        i_divstart = 1'b0;
        for (int k = 1; k <= 4; k++) begin @(posedge clk); #1; end
        @(negedge clk);
        check("busy ready_low", 32'(o_ready), 32'd0);
        i_divsigned = 1'b1; i_dividend = 32'd77; i_divisor = 32'd0; i_divstart = 1'b1;
        @(posedge clk); #1;
        i_divstart = 1'b0;
        lat = -1;
        for (int k = 6; k <= 60 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (o_done_vld) lat = k;
        end
        check("busy latency", 32'(lat), 32'd33);
        check("busy quotient", o_quotient, 32'd333);
        check("busy remainder", o_remainder, 32'd1);
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_done_vld || !o_ready) spurious++;
        end
        check("busy no_queue", 32'(spurious), 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        i_divsigned = 1'b1; i_dividend = 32'hFFFFFF9C; i_divisor = 32'd7; i_divstart = 1'b1;
        @(posedge clk); #1;
        i_divstart = 1'b0;
        for (e = 1; e <= 9; e++) begin @(posedge clk); #1; end
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("abort quotient", o_quotient, 32'd0);
        check("abort remainder", o_remainder, 32'd0);
        check("abort flags", {30'd0, o_done_vld, o_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_done_vld) spurious++;
        end
        check("abort no_done", 32'(spurious), 32'd0);
        model(1'b1, 32'hFFFFFF9C, 32'd7, mq, mr);
        run_op("after_abort", 1'b1, 32'hFFFFFF9C, 32'd7, mq, mr);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(0, 15));
                2:       b = -32'($urandom_range(1, 9));
                default: b = ($urandom_range(0, 1) != 0) ? 32'h80000000 : (a >> $urandom_range(0, 31));
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            model(s, a, b, mq, mr);
            run_op($sformatf("rnd%0d", i), s, a, b, mq, mr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
